// File: rtl/ab_input_conditioner.sv
// ---------------------------------------------------------------------------
// ab_input_conditioner
//   Front-end for the two-input (a, b) FSM. Each raw, asynchronous, possibly
//   bouncy level is synchronised into the clk domain and then debounced. The
//   result is a clean level plus one-cycle rise/fall pulses. The two channels
//   are identical and independent.
//
// Parameters
//   SYNC_STAGES      synchroniser depth per channel (>= 2)
//   DEBOUNCE_CYCLES  consecutive mismatching cycles before the output follows
//                    the synchronised level (>= 1)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; clears every flop
//   a_raw, b_raw   raw asynchronous input levels
//   a, b           debounced levels (registered)
//   a_rise/a_fall  one-cycle pulse on the edge where a changes 0->1 / 1->0
//   b_rise/b_fall  one-cycle pulse on the edge where b changes 0->1 / 1->0
// ---------------------------------------------------------------------------

// One conditioning channel: synchroniser chain followed by a debounce FSM.
module ab_debounce_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    // A 1-cycle debounce still needs a 1-bit counter to keep the types legal.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PEND} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_x;
    state_t                 state;
    logic [CW-1:0]          count;
    logic [CW-1:0]          run_cnt;

    assign sync_x = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // Mismatches already counted. In IDLE the count is zero by construction;
    // gating on state makes the restart-from-1 behaviour explicit.
    assign run_cnt = (state == PEND) ? count : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_x != level) begin
                // This edge is mismatch number run_cnt+1; toggle on the last one.
                if (run_cnt == LAST) begin
                    level <= sync_x;
                    rise  <= sync_x;
                    fall  <= ~sync_x;
                    count <= '0;
                    state <= IDLE;
                end else begin
                    count <= run_cnt + CW'(1);
                    state <= PEND;
                end
            end else begin
                // Agreement before completion: no partial credit.
                count <= '0;
                state <= IDLE;
            end
        end
    end
endmodule

module ab_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);
    localparam int NUM_CH = 2;

    // Channel 0 is a, channel 1 is b.
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;

    assign raw = {b_raw, a_raw};

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            ab_debounce_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (raw[ch]),
                .level(lvl[ch]),
                .rise (rise[ch]),
                .fall (fall[ch])
            );
        end
    endgenerate

    assign a      = lvl[0];
    assign b      = lvl[1];
    assign a_rise = rise[0];
    assign a_fall = fall[0];
    assign b_rise = rise[1];
    assign b_fall = fall[1];
endmodule

// File: doc/ab_input_conditioner.md
Name: ab_input_conditioner

Overview:
Upstream front-end for the lab3 two-input FSM (inputs a, b). Takes raw, asynchronous, bouncy button/switch levels, synchronises each into the clk domain, debounces them, and drives clean a/b levels straight into the FSM. It also provides one-cycle edge pulses for each input. The two channels are identical and fully independent.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per channel (minimum 2).
DEBOUNCE_CYCLES, 4, consecutive cycles that a synchronised level must differ from the output before the output follows it (minimum 1). Counter width is derived internally with $clog2.

Ports:
clk     input   1  system clock; all logic triggers on the rising edge.
rst_n   input   1  reset, asynchronous, active-low.
a_raw   input   1  raw asynchronous level for channel a.
b_raw   input   1  raw asynchronous level for channel b.
a       output  1  debounced level for channel a; feeds FSM input a.
b       output  1  debounced level for channel b; feeds FSM input b.
a_rise  output  1  one-cycle pulse when a goes 0->1.
a_fall  output  1  one-cycle pulse when a goes 1->0.
b_rise  output  1  one-cycle pulse when b goes 0->1.
b_fall  output  1  one-cycle pulse when b goes 1->0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: when rst_n=0, all sync flops, counters, FSM state and every output are 0 immediately, with no clock edge required. Outputs stay 0 while rst_n is low, whatever the raw inputs do.
- Synchroniser: per channel, a SYNC_STAGES flop chain. The last stage is sync_x. Nothing downstream uses a raw input directly.
- Debounce FSM, per channel, registered, two states:
  - IDLE: sync_x == x; count held at 0.
  - PEND: sync_x != x; count increments by 1 each cycle.
  - IDLE->PEND: on an edge where sync_x != x. That edge sets count=1.
  - PEND->IDLE without toggle: if sync_x == x on any edge before the count completes, count clears to 0. There is no partial credit; a new mismatch restarts from 1.
  - PEND->IDLE with toggle: on the edge where the mismatch has lasted DEBOUNCE_CYCLES consecutive edges, x inverts and count clears.
  - DEBOUNCE_CYCLES=1: x follows sync_x with one edge of extra delay.
- Latency: call the first rising edge that samples the new raw level edge 1. x changes on edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults this is edge 6, i.e. 50 ns after edge 1 at a 10 ns clock.
- Edge pulses: x_rise (or x_fall) is registered and asserted on the same edge that x changes. It is high for exactly one cycle. Rise and fall are never high together. A pulse never fires on reset assertion or on reset release.
- Channel independence: a and b may change on the same edge. Each channel's pulses are independent of the other channel.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change and no pulse.
- Reset mid-operation: asserting rst_n during PEND aborts the pending change. After release, a raw level that is still 1 needs the full SYNC_STAGES+DEBOUNCE_CYCLES edges, and then produces a rise pulse.
- Output timing: all outputs come directly from flops, with no combinational path from raw inputs.

Test Plan:
1. Reset with a_raw=1, b_raw=1 and rst_n=0 for 25 ns -> a=b=0 and all pulses 0 throughout. Release -> a=b=1 on the 6th edge after release, with a_rise and b_rise each high for one cycle (10 ns).
2. Clean press: a_raw 0->1, held 100 ns -> a=1 on edge 6 with a single a_rise pulse. Then a_raw 1->0 -> a=0 six edges later with a single a_fall pulse. b and b_* stay 0.
3. Glitch: b_raw high for 30 ns (3 cycles), then low -> b stays 0 and b_rise/b_fall never assert.
4. Bounce: a_raw goes 1,0,1,0,1 on successive cycles, then stays at 1 -> exactly one a_rise pulse. a rises 6 edges after the final 0->1 raw transition.
5. Async reset mid-count: a_raw rises, then rst_n drops 3 edges later, between clock edges -> all outputs read 0 before the next edge. After release with a_raw still 1 -> a rises on the 6th edge after release.
6. Simultaneous: a_raw and b_raw rise at the same time -> a and b rise on the same edge, with a_rise and b_rise both pulsing in that cycle.
